// File: rtl/uart_pkt_sched.sv
// uart_pkt_sched: round-robin scheduler sharing one UART TX FIFO between
// several sensor-data requesters. The winning requester's fixed-length payload
// is latched at grant time and serialised as header, source ID, payload and an
// optional checksum into the TX FIFO write port.
//
// Optional feature macro: UART_PKT_SUM_EN
//   defined   -> trailing checksum byte (SUM state), frame = PAYLOAD_BYTES+3
//   undefined -> no checksum, frame = PAYLOAD_BYTES+2
//
// Ports:
//   clk_in        in   clock
//   rst_n         in   asynchronous active-low reset
//   req_in        in   [NUM_REQ-1:0] level request per source
//   payload_in    in   flat payload bus, source i byte k at [(i*PAYLOAD_BYTES+k)*8 +: 8]
//   grant_out     out  [NUM_REQ-1:0] one-hot grant pulse, payload captured on this edge
//   fifo_full_in  in   TX FIFO full flag
//   fifo_wr_en    out  FIFO write strobe, never asserted while fifo_full_in is high
//   fifo_wr_data  out  FIFO write byte
//   busy          out  frame in progress
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a request; arbitrates, grants and latches payload
// HEAD    | emitting HEADER_BYTE
// ID      | emitting ID_BASE + granted index
// PAYLOAD | emitting latched payload byte byte_cnt
// SUM     | emitting the 8-bit checksum (UART_PKT_SUM_EN only)
module uart_pkt_sched #(
    parameter int          DATA_WIDTH    = 8,
    parameter int          NUM_REQ       = 3,
    parameter int          PAYLOAD_BYTES = 6,
    parameter logic [7:0]  HEADER_BYTE   = 8'h55,
    parameter logic [7:0]  ID_BASE       = 8'h50
) (
    input  logic                                      clk_in,
    input  logic                                      rst_n,
    input  logic [NUM_REQ-1:0]                        req_in,
    input  logic [NUM_REQ*PAYLOAD_BYTES*DATA_WIDTH-1:0] payload_in,
    output logic [NUM_REQ-1:0]                        grant_out,
    input  logic                                      fifo_full_in,
    output logic                                      fifo_wr_en,
    output logic [DATA_WIDTH-1:0]                     fifo_wr_data,
    output logic                                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(PAYLOAD_BYTES + 1);
    localparam int PL_W  = PAYLOAD_BYTES * DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEAD    = 3'd1,
        S_ID      = 3'd2,
        S_PAYLOAD = 3'd3,
        S_SUM     = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [PTR_W-1:0]        id_q, id_d;
    logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_d;
    logic [PL_W-1:0]         payload_q, payload_d;
`ifdef UART_PKT_SUM_EN
    logic [DATA_WIDTH-1:0]   sum_q, sum_d;
`endif

    logic [NUM_REQ-1:0]      req_rot;
    logic                    win_found;
    logic [PTR_W-1:0]        win_idx;
    logic [PL_W-1:0]         win_payload;
    logic [DATA_WIDTH-1:0]   cur_byte;
    logic                    wr_ok;

    // Rotate the request vector so bit 0 is the source at ptr; the first set
    // bit then gives the round-robin offset from ptr.
    always_comb begin
        req_rot   = NUM_REQ'({req_in, req_in} >> ptr_q);
        win_found = 1'b0;
        win_idx   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!win_found && req_rot[off]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'((int'(ptr_q) + off) % NUM_REQ);
            end
        end
    end

    always_comb begin
        win_payload = '0;
        for (int s = 0; s < NUM_REQ; s++) begin
            if (win_idx == PTR_W'(s)) begin
                win_payload = payload_in[s*PL_W +: PL_W];
            end
        end
    end

    always_comb begin
        cur_byte = '0;
        for (int k = 0; k < PAYLOAD_BYTES; k++) begin
            if (byte_cnt_q == CNT_W'(k)) begin
                cur_byte = payload_q[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Grant is a combinational IDLE-cycle pulse, gated by rst_n so it is
    // silent throughout reset.
    always_comb begin
        grant_out = '0;
        for (int s = 0; s < NUM_REQ; s++) begin
            grant_out[s] = rst_n && (state_q == S_IDLE) && win_found
                           && (win_idx == PTR_W'(s));
        end
    end

    assign wr_ok = !fifo_full_in;
    assign busy  = (state_q != S_IDLE);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        byte_cnt_d   = byte_cnt_q;
        payload_d    = payload_q;
`ifdef UART_PKT_SUM_EN
        sum_d        = sum_q;
`endif
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d    = S_HEAD;
                    ptr_d      = PTR_W'((int'(win_idx) + 1) % NUM_REQ);
                    id_d       = win_idx;
                    byte_cnt_d = '0;
                    payload_d  = win_payload;
`ifdef UART_PKT_SUM_EN
                    sum_d      = HEADER_BYTE + ID_BASE + DATA_WIDTH'(win_idx);
`endif
                end
            end
            S_HEAD: begin
                fifo_wr_en   = wr_ok;
                fifo_wr_data = HEADER_BYTE;
                if (wr_ok) begin
                    state_d = S_ID;
                end
            end
            S_ID: begin
                fifo_wr_en   = wr_ok;
                fifo_wr_data = ID_BASE + DATA_WIDTH'(id_q);
                if (wr_ok) begin
                    state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                fifo_wr_en   = wr_ok;
                fifo_wr_data = cur_byte;
                if (wr_ok) begin
`ifdef UART_PKT_SUM_EN
                    sum_d = sum_q + cur_byte;
`endif
                    if (byte_cnt_q == CNT_W'(PAYLOAD_BYTES - 1)) begin
                        byte_cnt_d = '0;
`ifdef UART_PKT_SUM_EN
                        state_d    = S_SUM;
`else
                        state_d    = S_IDLE;
`endif
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef UART_PKT_SUM_EN
            S_SUM: begin
                fifo_wr_en   = wr_ok;
                fifo_wr_data = sum_q;
                if (wr_ok) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            id_q       <= '0;
            byte_cnt_q <= '0;
            payload_q  <= '0;
`ifdef UART_PKT_SUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            byte_cnt_q <= byte_cnt_d;
            payload_q  <= payload_d;
`ifdef UART_PKT_SUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_pkt_sched.sv
module tb_uart_pkt_sched;

    localparam int NUM_REQ = 3;
    localparam int PB      = 6;
`ifdef UART_PKT_SUM_EN
    localparam int SUM_EN  = 1;
`else
    localparam int SUM_EN  = 0;
`endif
    localparam int FRAME_LEN = PB + 2 + SUM_EN;
    localparam int PERIOD    = FRAME_LEN + 1;

    logic                   clk_in = 1'b0;
    logic                   rst_n  = 1'b0;
    logic [NUM_REQ-1:0]     req_in = '0;
    logic [NUM_REQ*PB*8-1:0] payload_in = '0;
    logic [NUM_REQ-1:0]     grant_out;
    logic                   fifo_full_in = 1'b0;
    logic                   fifo_wr_en;
    logic [7:0]             fifo_wr_data;
    logic                   busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]         wq[$];
    int                 wc[$];
    logic [NUM_REQ-1:0] gq[$];
    int                 gc[$];
    logic               busy_log [0:4095];
    int                 cyc = 0;

    uart_pkt_sched dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .req_in       (req_in),
        .payload_in   (payload_in),
        .grant_out    (grant_out),
        .fifo_full_in (fifo_full_in),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .busy         (busy)
    );

    always #5 clk_in = ~clk_in;

    // Inputs change at the falling edge; outputs are sampled 2 ns later,
    // i.e. they show what the next rising edge will commit.
    always @(negedge clk_in) begin
        #2;
        if (fifo_wr_en) begin
            wq.push_back(fifo_wr_data);
            wc.push_back(cyc);
        end
        if (|grant_out) begin
            gq.push_back(grant_out);
            gc.push_back(cyc);
        end
        if (cyc < 4096) busy_log[cyc] = busy;
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        wq.delete(); wc.delete(); gq.delete(); gc.delete();
    endtask

    task automatic set_payload(input int src, input logic [PB*8-1:0] p);
        payload_in[src*PB*8 +: PB*8] = p;
    endtask

    function automatic logic [7:0] exp_byte(input int id, input logic [PB*8-1:0] p, input int idx);
        logic [7:0] s;
        if (idx == 0) return 8'h55;
        if (idx == 1) return 8'h50 + 8'(id);
        if (idx < PB + 2) return p[(idx-2)*8 +: 8];
        s = 8'h55 + 8'h50 + 8'(id);
        for (int k = 0; k < PB; k++) s = s + p[k*8 +: 8];
        return s;
    endfunction

    task automatic check_frame(input string tag, input int base, input int id,
                               input logic [PB*8-1:0] p, input int g_cyc, input bit cons);
        chk($sformatf("%s_len", tag), 32'(wq.size() >= base + FRAME_LEN), 32'd1);
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (base + i < wq.size())
                chk($sformatf("%s_b%0d", tag, i), 32'(wq[base+i]), 32'(exp_byte(id, p, i)));
        end
        if (base < wc.size())
            chk($sformatf("%s_first_cyc", tag), 32'(wc[base]), 32'(g_cyc + 1));
        if (cons && base + FRAME_LEN - 1 < wc.size())
            chk($sformatf("%s_last_cyc", tag), 32'(wc[base+FRAME_LEN-1]), 32'(g_cyc + FRAME_LEN));
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk_in); #3;
            if (!busy) done = 1'b1;
        end
        if (!done) chk({tag, "_idle_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic one_frame(input string tag, input int src, input logic [PB*8-1:0] p);
        clear_logs();
        @(negedge clk_in);
        set_payload(src, p);
        req_in = NUM_REQ'(1) << src;
        @(negedge clk_in);
        req_in = '0;
        wait_idle(tag);
        chk({tag, "_ngrant"}, 32'(gq.size()), 32'd1);
        if (gq.size() > 0) begin
            chk({tag, "_grant"}, 32'(gq[0]), 32'(NUM_REQ'(1) << src));
            check_frame(tag, 0, src, p, gc[0], 1'b1);
        end
        chk({tag, "_nwrites"}, 32'(wq.size()), 32'(FRAME_LEN));
        if (wc.size() > 0 && wc[wc.size()-1] + 1 < 4096)
            chk({tag, "_busy_drop"}, 32'(busy_log[wc[wc.size()-1] + 1]), 32'd0);
    endtask

    initial begin
        logic [PB*8-1:0] pl [NUM_REQ];
        bit got4;
        pl[0] = 48'h161514131211;
        pl[1] = 48'h262524232221;
        pl[2] = 48'h363534333231;

        // Reset state, with requests present to show grant is held off
        req_in = 3'b111;
        #12;
        chk("rst_busy",    32'(busy),         32'd0);
        chk("rst_wr_en",   32'(fifo_wr_en),   32'd0);
        chk("rst_wr_data", 32'(fifo_wr_data), 32'd0);
        chk("rst_grant",   32'(grant_out),    32'd0);
        req_in = '0;
        @(negedge clk_in); #1 rst_n = 1'b1;

        // Round robin with all requests held
        for (int s = 0; s < NUM_REQ; s++) set_payload(s, pl[s]);
        clear_logs();
        @(negedge clk_in);
        req_in = 3'b111;
        got4 = 1'b0;
        for (int i = 0; i < 100 && !got4; i++) begin
            @(negedge clk_in); #3;
            if (gq.size() >= 4) got4 = 1'b1;
        end
        if (!got4) chk("rr_grant_timeout", 32'd0, 32'd1);
        @(negedge clk_in);
        req_in = '0;
        wait_idle("rr");
        if (gq.size() >= 4) begin
            chk("rr_g0", 32'(gq[0]), 32'b001);
            chk("rr_g1", 32'(gq[1]), 32'b010);
            chk("rr_g2", 32'(gq[2]), 32'b100);
            chk("rr_g3", 32'(gq[3]), 32'b001);
            for (int f = 1; f < 4; f++)
                chk($sformatf("rr_period%0d", f), 32'(gc[f] - gc[f-1]), 32'(PERIOD));
            for (int f = 0; f < 4; f++)
                check_frame($sformatf("rr_f%0d", f), f*FRAME_LEN, f % NUM_REQ,
                            pl[f % NUM_REQ], gc[f], 1'b1);
        end

        // Single frames (ptr is 1 here, then 2)
        one_frame("single_s1", 1, 48'h060504030201);
        one_frame("single_s2", 2, 48'h060504030201);

        // Backpressure on payload byte 3 (ptr is 0; source 1 wins directly)
        clear_logs();
        @(negedge clk_in);
        set_payload(1, 48'hA5A4A3A2A1A0);
        req_in = 3'b010;
        @(negedge clk_in);
        req_in = '0;
        repeat (4) @(negedge clk_in);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            fifo_full_in = 1'b1;
            #1;
            chk($sformatf("bp_wr_en%0d", i),   32'(fifo_wr_en),   32'd0);
            chk($sformatf("bp_wr_data%0d", i), 32'(fifo_wr_data), 32'hA3);
        end
        @(negedge clk_in);
        fifo_full_in = 1'b0;
        wait_idle("bp");
        chk("bp_nwrites", 32'(wq.size()), 32'(FRAME_LEN));
        if (gq.size() > 0) check_frame("bp", 0, 1, 48'hA5A4A3A2A1A0, gc[0], 1'b0);
        if (wc.size() > 6) chk("bp_b3_cyc", 32'(wc[5]), 32'(wc[4] + 6));

        // Checksum wrap, payload latch, and grant while FIFO full (ptr is 2)
        clear_logs();
        @(negedge clk_in);
        set_payload(0, {PB{8'hFF}});
        req_in = 3'b001;
        fifo_full_in = 1'b1;
        @(negedge clk_in);
        req_in = '0;
        fifo_full_in = 1'b0;
        set_payload(0, '0);
        wait_idle("wrap");
        chk("wrap_ngrant", 32'(gq.size()), 32'd1);
        if (gq.size() > 0) begin
            chk("wrap_grant", 32'(gq[0]), 32'b001);
            check_frame("wrap", 0, 0, {PB{8'hFF}}, gc[0], 1'b1);
        end
`ifdef UART_PKT_SUM_EN
        if (wq.size() > 8) chk("wrap_sum_9f", 32'(wq[8]), 32'h9F);
`endif

        // Reset mid-frame (ptr is 1; source 0 wins, ptr becomes 1 again)
        set_payload(0, pl[0]);
        clear_logs();
        @(negedge clk_in);
        req_in = 3'b001;
        @(negedge clk_in);
        req_in = '0;
        repeat (3) @(negedge clk_in);
        #1 rst_n = 1'b0;
        req_in = 3'b011;
        #1;
        chk("mid_rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("mid_rst_busy",  32'(busy),       32'd0);
        chk("mid_rst_grant", 32'(grant_out),  32'd0);
        @(negedge clk_in);
        clear_logs();
        #1 rst_n = 1'b1;
        @(negedge clk_in);
        req_in = '0;
        wait_idle("after_rst");
        // ptr must be back at 0, so source 0 beats source 1
        chk("after_rst_ngrant", 32'(gq.size()), 32'd1);
        if (gq.size() > 0) begin
            chk("after_rst_grant", 32'(gq[0]), 32'b001);
            check_frame("after_rst", 0, 0, pl[0], gc[0], 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_pkt_sched.md
# uart_pkt_sched

Round-robin packet scheduler that shares the single UART transmit path between several sensor-data requesters (attitude angles, raw accel/gyro, status). It arbitrates among pending requests, latches the winner's fixed-length payload, and serialises it into a framed byte stream written into the TX FIFO that feeds `uart_tx`. Each frame is header, source ID, payload and an optional checksum. The block sits between the MPU6050 processing logic and the TX FIFO write port.

## Interface
- `DATA_WIDTH`, 8: byte width of the FIFO write data; fixed at 8.
- `NUM_REQ`, 3: number of requesters, from 2 to 8.
- `PAYLOAD_BYTES`, 6: payload bytes per frame, from 1 to 16.
- `HEADER_BYTE`, 8'h55: frame start byte.
- `ID_BASE`, 8'h50: the ID byte for requester i is `ID_BASE + i`.

Ports:
- `clk_in`  in  1  clock.
- `rst_n`  in  1  reset: asynchronous, active-low. Clock is `clk_in`.
- `req_in`  in  NUM_REQ  level request per source.
- `payload_in`  in  NUM_REQ*PAYLOAD_BYTES*8  flat payload bus. Source i, byte k is at `[(i*PAYLOAD_BYTES+k)*8 +: 8]`.
- `grant_out`  out  NUM_REQ  one-hot, one-cycle pulse. The winner's payload is captured on this edge.
- `fifo_full_in`  in  1  TX FIFO full flag.
- `fifo_wr_en`  out  1  FIFO write strobe.
- `fifo_wr_data`  out  8  FIFO write byte.
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- FSM states:
  - IDLE: if `req_in` ≠ 0, assert `grant_out`, latch the payload, load the checksum with `HEADER_BYTE + ID`, and go to HEAD.
  - HEAD → ID → PAYLOAD → SUM → IDLE.
  - Each emitting state advances only on a cycle in which a write occurs.
- Arbitration is round-robin over pointer `ptr` (reset value 0). The first requesting index searched from `ptr` upward (modulo NUM_REQ) wins. After a grant to index i, `ptr` becomes `(i+1) mod NUM_REQ`.
- `req_in` is sampled only in IDLE. A request that drops before it is granted is lost without error. A request held high after its grant counts as a new request.
- `fifo_wr_en` is `(state ∈ {HEAD, ID, PAYLOAD, SUM}) && !fifo_full_in`. It is combinational, so a write is never issued into a full FIFO.
- `fifo_wr_data` carries the byte for the current state: `HEADER_BYTE`, then `ID_BASE + i`, then payload byte `byte_cnt`, then the checksum. It holds stable while the FIFO is full.
- `byte_cnt` counts 0 to PAYLOAD_BYTES-1 in PAYLOAD and increments per write. When the write at PAYLOAD_BYTES-1 occurs, the FSM goes to SUM.
- Checksum: 8-bit sum modulo 256 of the header, ID and all payload bytes. The carry is discarded.
- The latched payload is immune to changes on `payload_in` after the grant.

## Timing
- Reset values:
  - State IDLE, `ptr` 0, `byte_cnt` 0, checksum 0.
  - `fifo_wr_en` 0, `fifo_wr_data` 8'h00, `busy` 0.
  - `grant_out` is forced to 0 while `rst_n` is low.
- Grant to first write: the grant is in cycle t and the header is written in cycle t+1 if the FIFO is not full.
- With no backpressure, a frame is PAYLOAD_BYTES+3 consecutive writes. There is at least 1 IDLE cycle between frames, so the back-to-back period is PAYLOAD_BYTES+4 cycles.
- Backpressure: each cycle with `fifo_full_in` high stalls the FSM by one cycle. No byte is dropped or duplicated.
- Reset mid-frame aborts the frame immediately. Bytes already written stay in the FIFO; the receiver resynchronises on `HEADER_BYTE`.
- If a request and `fifo_full_in` are high together in IDLE, the grant still occurs. The stall applies from HEAD onward.

## Configuration
- `UART_PKT_SUM_EN` defined: the SUM state is present and the frame has PAYLOAD_BYTES+3 bytes.
- `UART_PKT_SUM_EN` undefined: the SUM state and checksum logic are removed. PAYLOAD goes directly to IDLE and the frame has PAYLOAD_BYTES+2 bytes.

## Test plan
Default parameters, `UART_PKT_SUM_EN` defined unless stated.
- Single frame: `req_in` = 3'b010 with payload 01..06 → one `grant_out` pulse of 3'b010, then 9 consecutive writes: 55 51 01 02 03 04 05 06 BB.
- Round-robin: `req_in` = 3'b111 held high → grants in order 001, 010, 100, 001. Frame starts are 10 cycles apart, and the ID bytes are 50, 51, 52, 50.
- Backpressure: `fifo_full_in` high for 5 cycles while payload byte 3 is pending → `fifo_wr_en` low for those 5 cycles and `fifo_wr_data` held. The write resumes with byte 3, and the total frame is still 9 bytes in the correct order.
- Checksum wrap and payload latch: source 0 with payload FF×6, and `payload_in` changed the cycle after the grant → frame is 55 50 FF FF FF FF FF FF 9F.
- Reset mid-frame: `rst_n` pulsed low during PAYLOAD → `fifo_wr_en` goes 0 asynchronously, `busy` 0 and `ptr` 0. The next request produces a complete fresh frame starting with 55.
- Macro undefined: single frame from source 2 with payload 01..06 → 8 writes: 55 52 01..06, then `busy` drops.
